// File: rtl/curve25519_pkg.sv
// -----------------------------------------------------------------------------
// curve25519_pkg
// Shared field definitions for GF(p), p = 2^255 - 19: element type, modulus,
// projective-to-affine converter state encoding and two small field helpers
// used by the inverter datapath.
// -----------------------------------------------------------------------------
package curve25519_pkg;

  localparam int FE_W = 255;

  typedef logic [FE_W-1:0] fe_t;

  // 2^255 - 19: 250 ones followed by 0b01101
  localparam fe_t P_MOD = {{(FE_W-5){1'b1}}, 5'b01101};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INV  = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } conv_state_t;

  // a/2 mod p for a < p. Odd values get p added first so the sum is even;
  // the sum needs one extra bit before the shift.
  function automatic fe_t fe_half(input fe_t a);
    logic [FE_W:0] t;
    t = a[0] ? ({1'b0, a} + {1'b0, P_MOD}) : {1'b0, a};
    return t[FE_W:1];
  endfunction

  // (a - b) mod p for a, b < p. On borrow the 255-bit wrap of a - b + p is
  // exactly the reduced difference, since that value lies in [0, p).
  function automatic fe_t fe_sub(input fe_t a, input fe_t b);
    return (a >= b) ? (a - b) : (a - b + P_MOD);
  endfunction

endpackage

// File: rtl/mod_mul_serial.sv
// -----------------------------------------------------------------------------
// mod_mul_serial
// Bit-serial interleaved modular multiplier, result = a * b mod p.
// Scans b MSB-first, one bit per cycle, for 255 cycles after a start.
//
// Ports:
//   i_clk     clock, rising edge
//   i_rst_n   asynchronous active-low reset
//   i_start   load a/b and clear the accumulator
//   i_a       multiplicand, < p
//   i_b       multiplier,   < p
//   o_result  accumulator; holds the final product once the run ends
//   o_done    high during the cycle in which the last step executes, so the
//             product is valid on o_result from the following edge on
// -----------------------------------------------------------------------------
module mod_mul_serial
  import curve25519_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [FE_W-1:0] i_a,
  input  logic [FE_W-1:0] i_b,
  output logic [FE_W-1:0] o_result,
  output logic            o_done
);

  fe_t        r_a;
  fe_t        r_b;
  fe_t        r_acc;
  logic [8:0] r_cnt;
  logic       r_done;
  fe_t        w_acc_next;

  // acc <- (2*acc mod p) + (bit ? a : 0) mod p, each half with one
  // conditional subtract of p (both partial sums stay below 2p).
  function automatic fe_t mul_step(input fe_t acc, input fe_t a, input logic b_i);
    logic [FE_W:0] t;
    fe_t           d;
    t = {acc, 1'b0};
    if (t >= {1'b0, P_MOD}) t = t - {1'b0, P_MOD};
    d = t[FE_W-1:0];
    t = {1'b0, d} + (b_i ? {1'b0, a} : {(FE_W+1){1'b0}});
    if (t >= {1'b0, P_MOD}) t = t - {1'b0, P_MOD};
    return t[FE_W-1:0];
  endfunction

  assign w_acc_next = mul_step(r_acc, r_a, r_b[FE_W-1]);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (i_start) begin
      r_a    <= i_a;
      r_b    <= i_b;
      r_acc  <= '0;
      r_cnt  <= 9'd255;
      r_done <= 1'b0;
    end else if (r_cnt != 9'd0) begin
      r_acc  <= w_acc_next;
      r_b    <= {r_b[FE_W-2:0], 1'b0};
      r_cnt  <= r_cnt - 9'd1;
      // flag the cycle holding the final step so the caller can leave its
      // wait state on the same edge that writes the last accumulator value
      r_done <= (r_cnt == 9'd2);
    end else begin
      r_done <= 1'b0;
    end
  end

  assign o_result = r_acc;
  assign o_done   = r_done;

endmodule

// File: rtl/proj_to_affine.sv
// -----------------------------------------------------------------------------
// proj_to_affine
// Converts a projective Ed25519 point (X, Y, Z) into affine (x, y) =
// (X/Z, Y/Z) mod p, p = 2^255 - 19. Z^-1 comes from a binary extended
// Euclidean inverter (one micro-step per cycle); X*Zinv and Y*Zinv are then
// formed by two bit-serial multipliers running in parallel.
//
// Ports:
//   i_clk       clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_start     start request, sampled only in S_IDLE
//   i_x/i_y/i_z projective coordinates, each < p
//   o_x/o_y     affine result, held until the next completion
//   o_busy      high while a job is in progress
//   o_z_zero    set at completion when Z = 0, cleared on the next start
//   o_finished  one-cycle completion pulse
// -----------------------------------------------------------------------------
module proj_to_affine
  import curve25519_pkg::*;
#(
  parameter int W = 255  // must equal FE_W; the arithmetic is fixed to p
)(
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_y,
  input  logic [W-1:0] i_z,
  output logic [W-1:0] o_x,
  output logic [W-1:0] o_y,
  output logic         o_busy,
  output logic         o_z_zero,
  output logic         o_finished
);

  conv_state_t r_state;
  fe_t         r_x;
  fe_t         r_y;
  fe_t         r_u;
  fe_t         r_v;
  fe_t         r_x1;
  fe_t         r_x2;
  logic        r_zero_job;
  fe_t         r_o_x;
  fe_t         r_o_y;
  logic        r_z_zero;
  logic        r_busy;
  logic        r_finished;

  logic        w_u_zero;
  logic        w_u_one;
  logic        w_v_one;
  logic        w_launch;
  fe_t         w_zinv;
  fe_t         w_mx;
  fe_t         w_my;
  logic        w_mx_done;
  logic        w_my_done;

  assign w_u_zero = (r_u == '0);
  assign w_u_one  = (r_u == fe_t'(1));
  assign w_v_one  = (r_v == fe_t'(1));

  // Multipliers are loaded on the edge that ends the inversion; Zinv is
  // taken straight from whichever coefficient register is finished.
  assign w_launch = (r_state == S_INV) && !w_u_zero && (w_u_one || w_v_one);
  assign w_zinv   = w_u_one ? r_x1 : r_x2;

  mod_mul_serial u_mul_x (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_start  (w_launch),
    .i_a      (r_x),
    .i_b      (w_zinv),
    .o_result (w_mx),
    .o_done   (w_mx_done)
  );

  mod_mul_serial u_mul_y (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_start  (w_launch),
    .i_a      (r_y),
    .i_b      (w_zinv),
    .o_result (w_my),
    .o_done   (w_my_done)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_x        <= '0;
      r_y        <= '0;
      r_u        <= '0;
      r_v        <= '0;
      r_x1       <= '0;
      r_x2       <= '0;
      r_zero_job <= 1'b0;
      r_o_x      <= '0;
      r_o_y      <= '0;
      r_z_zero   <= 1'b0;
      r_busy     <= 1'b0;
      r_finished <= 1'b0;
    end else begin
      r_finished <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_x        <= i_x;
            r_y        <= i_y;
            r_u        <= i_z;
            r_v        <= P_MOD;
            r_x1       <= fe_t'(1);
            r_x2       <= '0;
            r_zero_job <= 1'b0;
            r_z_zero   <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_INV;
          end
        end

        S_INV: begin
          // u = 0 only arises from Z = 0 (gcd(Z, p) = 1 otherwise stops the
          // loop at 1 first); it is tested before the evenness rules, which
          // would never terminate on 0.
          if (w_u_zero) begin
            r_zero_job <= 1'b1;
            r_state    <= S_DONE;
          end else if (w_u_one || w_v_one) begin
            r_state <= S_MUL;
          end else if (!r_u[0]) begin
            r_u  <= r_u >> 1;
            r_x1 <= fe_half(r_x1);
          end else if (!r_v[0]) begin
            r_v  <= r_v >> 1;
            r_x2 <= fe_half(r_x2);
          end else if (r_u >= r_v) begin
            r_u  <= r_u - r_v;
            r_x1 <= fe_sub(r_x1, r_x2);
          end else begin
            r_v  <= r_v - r_u;
            r_x2 <= fe_sub(r_x2, r_x1);
          end
        end

        S_MUL: begin
          // done flags the final multiplier step, so S_DONE begins with the
          // products already settled
          if (w_mx_done && w_my_done) r_state <= S_DONE;
        end

        S_DONE: begin
          r_o_x      <= r_zero_job ? '0 : w_mx;
          r_o_y      <= r_zero_job ? '0 : w_my;
          r_z_zero   <= r_zero_job;
          r_finished <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_x        = r_o_x;
  assign o_y        = r_o_y;
  assign o_busy     = r_busy;
  assign o_z_zero   = r_z_zero;
  assign o_finished = r_finished;

endmodule

// File: tb/tb_proj_to_affine.sv
module tb_proj_to_affine;

  typedef logic [254:0] fe_t;

  localparam int LIMIT = 1400;
  localparam int NRAND = 25;

  logic clk;
  logic rst_n;
  logic start;
  fe_t  in_x, in_y, in_z;
  fe_t  out_x, out_y;
  logic busy, z_zero, finished;

  int total = 0;
  int bad   = 0;

  fe_t P;
  fe_t BX, BY;

  proj_to_affine #(.W(255)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_x        (in_x),
    .i_y        (in_y),
    .i_z        (in_z),
    .o_x        (out_x),
    .o_y        (out_y),
    .o_busy     (busy),
    .o_z_zero   (z_zero),
    .o_finished (finished)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (plain field arithmetic) ----------------
  function automatic fe_t mmul(input fe_t a, input fe_t b);
    logic [511:0] pr;
    pr = 512'(a) * 512'(b);
    pr = pr % 512'(P);
    return pr[254:0];
  endfunction

  // Z^-1 by Fermat: Z^(p-2)
  function automatic fe_t minv(input fe_t z);
    fe_t r, e;
    r = 255'd1;
    e = P - 255'd2;
    for (int i = 254; i >= 0; i--) begin
      r = mmul(r, r);
      if (e[i]) r = mmul(r, z);
    end
    return r;
  endfunction

  // Number of binary-Euclid micro-steps before u or v reaches 1.
  function automatic int model_ninv(input fe_t z);
    logic [255:0] u, v;
    int n;
    u = 256'(z);
    v = 256'(P);
    n = 0;
    while (u != 256'd1 && v != 256'd1 && n < 5000) begin
      if (!u[0])        u = u >> 1;
      else if (!v[0])   v = v >> 1;
      else if (u >= v)  u = u - v;
      else              v = v - u;
      n++;
    end
    return n;
  endfunction

  function automatic fe_t rand_fe();
    logic [255:0] r;
    do begin
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    end while (r[254:0] >= P);
    return r[254:0];
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one conversion, checks latency/results/pulse width against the model.
  task automatic run_job(input fe_t x, input fe_t y, input fe_t z, input bit glitch,
                         input string tag, output fe_t ox, output fe_t oy);
    fe_t  ex, ey, zi;
    int   lat_exp, lat;
    logic zz;
    if (z == '0) begin
      ex = '0; ey = '0; lat_exp = 2; zz = 1'b1;
    end else begin
      zi = minv(z);
      ex = mmul(x, zi);
      ey = mmul(y, zi);
      lat_exp = model_ninv(z) + 257;
      zz = 1'b0;
    end
    @(negedge clk);
    in_x = x; in_y = y; in_z = z; start = 1'b1;
    @(posedge clk);  // edge 0
    #1 start = 1'b0;
    @(negedge clk);
    chk({tag, "_busy"}, 256'(busy), 256'd1);
    lat = -1;
    for (int k = 1; k <= LIMIT; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (finished) begin lat = k; break; end
      if (glitch && k == 40) begin
        start = 1'b1; in_x = rand_fe(); in_y = rand_fe(); in_z = 255'd7;
      end
      if (glitch && k == 41) start = 1'b0;
    end
    chk({tag, "_latency"}, 256'(lat), 256'(lat_exp));
    chk({tag, "_x"}, 256'(out_x), 256'(ex));
    chk({tag, "_y"}, 256'(out_y), 256'(ey));
    chk({tag, "_zzero"}, 256'(z_zero), 256'(zz));
    ox = out_x;
    oy = out_y;
    @(negedge clk);
    chk({tag, "_pulse1"}, 256'(finished), 256'd0);
    chk({tag, "_idle"}, 256'(busy), 256'd0);
  endtask

  initial begin : main
    fe_t ox, oy, k, z3, sx, sy, sz;
    int  n3, fin_seen;

    P  = 255'((256'd1 << 255) - 256'd19);
    BX = 255'h216936D3CD6E53FEC0A4E231FDD6DC5C692CC7609525A7B2C9562D608F25D51A;
    BY = 255'h6666666666666666666666666666666666666666666666666666666666666658;

    rst_n = 1'b0; start = 1'b0; in_x = '0; in_y = '0; in_z = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_x", 256'(out_x), 256'd0);
    chk("rst_y", 256'(out_y), 256'd0);
    chk("rst_busy", 256'(busy), 256'd0);
    chk("rst_zzero", 256'(z_zero), 256'd0);
    chk("rst_fin", 256'(finished), 256'd0);
    rst_n = 1'b1;

    // basepoint passthrough, Z = 1 -> latency 257
    run_job(BX, BY, 255'd1, 1'b0, "base", ox, oy);
    chk("base_x_const", 256'(ox), 256'(BX));
    chk("base_y_const", 256'(oy), 256'(BY));

    // simple inverse
    run_job(255'd2, 255'd4, 255'd2, 1'b0, "simple", ox, oy);
    chk("simple_x_const", 256'(ox), 256'd1);
    chk("simple_y_const", 256'(oy), 256'd2);

    // Z = 0
    run_job(255'd3, 255'd3, 255'd0, 1'b0, "zeroz", ox, oy);

    // Z = p - 1
    run_job(255'd5, 255'd7, P - 255'd1, 1'b0, "negz", ox, oy);
    chk("negz_x_const", 256'(ox), 256'(P - 255'd5));
    chk("negz_y_const", 256'(oy), 256'(P - 255'd7));

    // reset in the middle of a Z = 3 job
    z3 = 255'd3;
    n3 = model_ninv(z3);
    @(negedge clk);
    in_x = 255'd10; in_y = 255'd11; in_z = z3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_x", 256'(out_x), 256'd0);
    chk("abort_y", 256'(out_y), 256'd0);
    chk("abort_busy", 256'(busy), 256'd0);
    chk("abort_zzero", 256'(z_zero), 256'd0);
    chk("abort_fin", 256'(finished), 256'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fin_seen = 0;
    for (int c = 0; c < n3 + 260; c++) begin
      @(negedge clk);
      if (finished) fin_seen++;
    end
    chk("abort_no_finish", 256'(fin_seen), 256'd0);
    chk("abort_still_idle", 256'(busy), 256'd0);

    // re-run the same job with a stray start pulse mid-job
    run_job(255'd10, 255'd11, z3, 1'b1, "rerun", ox, oy);

    // projective multiple of the basepoint (what the scalar multiplier hands
    // over for M = 1 with an arbitrary Z) must map back to the basepoint
    k = rand_fe();
    if (k == '0) k = 255'd12345;
    run_job(mmul(BX, k), mmul(BY, k), k, 1'b0, "chain", ox, oy);
    chk("chain_x_base", 256'(ox), 256'(BX));
    chk("chain_y_base", 256'(oy), 256'(BY));

    // random triples, back to back
    for (int i = 0; i < NRAND; i++) begin
      sx = rand_fe();
      sy = rand_fe();
      if (i % 5 == 0) sz = 255'($urandom_range(1, 1000));
      else            sz = rand_fe();
      if (i == 7) sz = '0;
      run_job(sx, sy, sz, 1'b0, $sformatf("rand%0d", i), ox, oy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
